// File: rtl/mapping_group_pkg.sv
// Shared types and constants for the mapping-group sequencer.
//   ctrl_state_e   : sequencer states
//   MODE_RBR/PAR   : values of mode_i / mode_o
//   NUM_PLANES_DEF : default number of bit-planes per operation
package mapping_group_pkg;

    typedef enum logic [3:0] {
        IDLE,
        REQ1,
        WAIT1,
        WR1,
        REQ2,
        WAIT2,
        WR2,
        RD,
        ACC,
        OUT
    } ctrl_state_e;

    localparam logic        MODE_RBR       = 1'b0;
    localparam logic        MODE_PAR       = 1'b1;
    localparam int unsigned NUM_PLANES_DEF = 4;

endpackage

// File: rtl/mapping_group_wdt.sv
// Wait-state watchdog for mapping_group_ctrl.
// Counts WAIT cycles; expire is asserted combinationally when the count
// that will be held next cycle equals TIMEOUT_CYC, so the parent can
// register it and present the error in that very cycle.
//   clk, rst_n : clock, async active-low reset
//   load       : entering a WAIT state (count restarts at 1)
//   count      : staying in the same WAIT state
//   expire     : next cycle is WAIT cycle number TIMEOUT_CYC
module mapping_group_wdt #(
    parameter int unsigned TIMEOUT_CYC = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CW'(1);
        end else if (count) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire = (load || count) && (cnt_d == CW'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mapping_group_ctrl.sv
// Sequencer in front of mapping_group_top. One start pulse runs NUM_PLANES
// bit-planes: per plane one (row-by-row) or two (parallel) ADC conversions
// with buffer write strobes, then read/shift/accumulate; finally the
// accumulator read is pulsed together with done_o.
// Optional feature: define MAPPING_CTRL_TIMEOUT_EN to abort a WAIT state
// after TIMEOUT_CYC cycles without adc_valid_i (err_o pulse).
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   start_i, mode_i      start request (IDLE only), mode sampled at accept
//   adc_valid_i          ADC result valid (honoured only in WAIT states)
//   pim_req_o, pim_sel_o conversion request and half select
//   mode_o               latched mode
//   buf_write_en_1_o/2_o, buf_read_en_o, shift_count_o,
//   accum_buf_write_o, accum_buf_read_o   strobes to mapping_group_top
//   busy_o, done_o, err_o                 status
module mapping_group_ctrl
    import mapping_group_pkg::*;
#(
    parameter int unsigned NUM_PLANES = NUM_PLANES_DEF,
    parameter int unsigned SHIFT_W    = 2
`ifdef MAPPING_CTRL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC = 256
`endif
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               mode_i,
    input  logic               adc_valid_i,
    output logic               pim_req_o,
    output logic               pim_sel_o,
    output logic               mode_o,
    output logic               buf_write_en_1_o,
    output logic               buf_write_en_2_o,
    output logic               buf_read_en_o,
    output logic [SHIFT_W-1:0] shift_count_o,
    output logic               accum_buf_write_o,
    output logic               accum_buf_read_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o
);

    ctrl_state_e        state_q, state_d;
    logic [SHIFT_W-1:0] plane_q, plane_d;
    logic               mode_q, mode_d;
    logic               err_q;
    logic               abort;

    logic req_q, sel_q, wr1_q, wr2_q, rd_q, accw_q, accr_q, busy_q;
    logic req_d, sel_d, wr1_d, wr2_d, rd_d, accw_d, accr_d, busy_d;

    // Next state. The plane counter doubles as shift_count_o, so it is
    // cleared when leaving the last ACC to present 0 during OUT.
    always_comb begin
        state_d = state_q;
        plane_d = plane_q;
        mode_d  = mode_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = REQ1;
                    mode_d  = mode_i;
                    plane_d = '0;
                end
            end
            REQ1: state_d = WAIT1;
            WAIT1: begin
                if (abort) begin
                    state_d = IDLE;
                    plane_d = '0;
                end else if (adc_valid_i) begin
                    state_d = WR1;
                end
            end
            WR1:  state_d = (mode_q == MODE_PAR) ? REQ2 : RD;
            REQ2: state_d = WAIT2;
            WAIT2: begin
                if (abort) begin
                    state_d = IDLE;
                    plane_d = '0;
                end else if (adc_valid_i) begin
                    state_d = WR2;
                end
            end
            WR2: state_d = RD;
            RD:  state_d = ACC;
            ACC: begin
                if (plane_q == SHIFT_W'(NUM_PLANES - 1)) begin
                    state_d = OUT;
                    plane_d = '0;
                end else begin
                    state_d = REQ1;
                    plane_d = plane_q + 1'b1;
                end
            end
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each strobe
    // is high exactly for the cycles spent in its state.
    always_comb begin
        req_d  = (state_d == REQ1) || (state_d == REQ2);
        sel_d  = (state_d == REQ2);
        wr1_d  = (state_d == WR1);
        wr2_d  = (state_d == WR2);
        rd_d   = (state_d == RD) || (state_d == ACC);
        accw_d = (state_d == ACC);
        accr_d = (state_d == OUT);
        busy_d = (state_d != IDLE);
    end

`ifdef MAPPING_CTRL_TIMEOUT_EN
    logic wait_next, wdt_load, wdt_count, wdt_expire;

    assign wait_next = (state_d == WAIT1) || (state_d == WAIT2);
    assign wdt_load  = wait_next && (state_d != state_q);
    assign wdt_count = wait_next && (state_d == state_q);

    mapping_group_wdt #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdt (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .load  (wdt_load),
        .count (wdt_count),
        .expire(wdt_expire)
    );

    // err_q is high during the last permitted WAIT cycle; the FSM leaves
    // on the following edge regardless of adc_valid_i in that cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= wdt_expire;
        end
    end

    assign abort = err_q;
`else
    assign err_q = 1'b0;
    assign abort = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            plane_q <= '0;
            mode_q  <= 1'b0;
            req_q   <= 1'b0;
            sel_q   <= 1'b0;
            wr1_q   <= 1'b0;
            wr2_q   <= 1'b0;
            rd_q    <= 1'b0;
            accw_q  <= 1'b0;
            accr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            mode_q  <= mode_d;
            req_q   <= req_d;
            sel_q   <= sel_d;
            wr1_q   <= wr1_d;
            wr2_q   <= wr2_d;
            rd_q    <= rd_d;
            accw_q  <= accw_d;
            accr_q  <= accr_d;
            busy_q  <= busy_d;
        end
    end

    assign pim_req_o         = req_q;
    assign pim_sel_o         = sel_q;
    assign mode_o            = mode_q;
    assign buf_write_en_1_o  = wr1_q;
    assign buf_write_en_2_o  = wr2_q;
    assign buf_read_en_o     = rd_q;
    assign shift_count_o     = plane_q;
    assign accum_buf_write_o = accw_q;
    assign accum_buf_read_o  = accr_q;
    assign busy_o            = busy_q;
    assign done_o            = accr_q;
    assign err_o             = err_q;

endmodule

// File: tb/tb_mapping_group_ctrl.sv
// Self-checking bench for mapping_group_ctrl: a table of directed
// operations, randomized operations scored against a latency/event model,
// and hand-written reset and timeout sequences.
module tb_mapping_group_ctrl;
    import mapping_group_pkg::*;

    localparam int unsigned N      = 4;
    localparam int unsigned BUDGET = 200;

    logic       clk;
    logic       rst_ni;
    logic       start_i;
    logic       mode_i;
    logic       adc_valid_i;
    logic       pim_req_o, pim_sel_o, mode_o;
    logic       buf_write_en_1_o, buf_write_en_2_o, buf_read_en_o;
    logic [1:0] shift_count_o;
    logic       accum_buf_write_o, accum_buf_read_o, busy_o, done_o, err_o;
    logic [12:0] outs;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [7:0][7:0] cur_dly = '0;
    logic            noise_en = 1'b0;

    mapping_group_ctrl #(
        .NUM_PLANES(N),
        .SHIFT_W   (2)
`ifdef MAPPING_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT_CYC(16)
`endif
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .start_i          (start_i),
        .mode_i           (mode_i),
        .adc_valid_i      (adc_valid_i),
        .pim_req_o        (pim_req_o),
        .pim_sel_o        (pim_sel_o),
        .mode_o           (mode_o),
        .buf_write_en_1_o (buf_write_en_1_o),
        .buf_write_en_2_o (buf_write_en_2_o),
        .buf_read_en_o    (buf_read_en_o),
        .shift_count_o    (shift_count_o),
        .accum_buf_write_o(accum_buf_write_o),
        .accum_buf_read_o (accum_buf_read_o),
        .busy_o           (busy_o),
        .done_o           (done_o),
        .err_o            (err_o)
    );

    assign outs = {pim_req_o, pim_sel_o, mode_o, buf_write_en_1_o, buf_write_en_2_o,
                   buf_read_en_o, shift_count_o, accum_buf_write_o, accum_buf_read_o,
                   busy_o, done_o, err_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ADC responder: request number i of an operation gets adc_valid_i in
    // WAIT cycle cur_dly[i]+1; 255 means never answer. With noise_en it
    // also fires stray valids while the buffer is being read.
    initial begin
        int unsigned idx;
        int unsigned cd;
        adc_valid_i = 1'b0;
        idx = 0;
        cd  = 0;
        forever begin
            @(negedge clk);
            adc_valid_i = 1'b0;
            if (!busy_o) begin
                idx = 0;
                cd  = 0;
            end else begin
                if (cd != 0) begin
                    cd--;
                    if (cd == 0) adc_valid_i = 1'b1;
                end
                if (pim_req_o) begin
                    cd  = (cur_dly[idx % 8] == 8'd255) ? 0 : int'(cur_dly[idx % 8]) + 1;
                    idx++;
                end
                if (noise_en && buf_read_en_o && ($urandom_range(0, 1) == 1)) adc_valid_i = 1'b1;
            end
        end
    end

    // Reference: every plane costs 5 cycles (rbr) or 8 (parallel), plus the
    // single OUT cycle, plus each extra WAIT cycle of each request.
    function automatic int unsigned model_lat(input logic mode, input logic [7:0][7:0] dly);
        int unsigned nreq = (mode == MODE_PAR) ? 2 * N : N;
        int unsigned s    = ((mode == MODE_PAR) ? 8 : 5) * N + 1;
        for (int unsigned i = 0; i < nreq; i++) s += dly[i];
        return s;
    endfunction

    task automatic run_op(input logic mode, input logic noise, input logic [7:0][7:0] dly,
                          input int unsigned exp_lat, input int unsigned exp_req,
                          input int unsigned exp_wr2, input string tag);
        int unsigned nreq = 0, nwr1 = 0, nwr2 = 0, nacc = 0, nerr = 0;
        int unsigned done_at = 0, accr_at = 0, overlap = 0, acc_bad = 0, busy_bad = 0, mode_bad = 0;
        int unsigned last_rd = 0;
        int unsigned sel_q[$];
        int unsigned rd_q[$];
        cur_dly  = dly;
        noise_en = noise;
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = mode;
        for (int unsigned k = 1; k <= BUDGET; k++) begin
            @(negedge clk);
            start_i = noise ? ($urandom_range(0, 2) == 0) : 1'b0;
            mode_i  = 1'($urandom);
            if (!busy_o) busy_bad++;
            if (mode_o != mode) mode_bad++;
            if (int'(buf_write_en_1_o) + int'(buf_write_en_2_o) + int'(buf_read_en_o) > 1) overlap++;
            if (pim_req_o) begin
                nreq++;
                sel_q.push_back(int'(pim_sel_o));
            end
            nwr1 += int'(buf_write_en_1_o);
            nwr2 += int'(buf_write_en_2_o);
            if (accum_buf_write_o) begin
                nacc++;
                if (!buf_read_en_o || int'(shift_count_o) != last_rd) acc_bad++;
            end else if (buf_read_en_o) begin
                last_rd = int'(shift_count_o);
                rd_q.push_back(last_rd);
            end
            if (err_o) nerr++;
            if (accum_buf_read_o && accr_at == 0) accr_at = k;
            if (done_o) begin
                done_at = k;
                if (noise) start_i = 1'b1;
                break;
            end
        end
        @(negedge clk);
        start_i  = 1'b0;
        noise_en = 1'b0;
        chk({tag, ".idle_after_done"}, 32'(busy_o), 0);
        chk({tag, ".done_cycle"}, done_at, exp_lat);
        chk({tag, ".accr_cycle"}, accr_at, exp_lat);
        chk({tag, ".busy_drop"}, busy_bad, 0);
        chk({tag, ".mode_hold"}, mode_bad, 0);
        chk({tag, ".strobe_overlap"}, overlap, 0);
        chk({tag, ".n_req"}, nreq, exp_req);
        chk({tag, ".n_wr1"}, nwr1, N);
        chk({tag, ".n_wr2"}, nwr2, exp_wr2);
        chk({tag, ".n_acc"}, nacc, N);
        chk({tag, ".acc_shift"}, acc_bad, 0);
        chk({tag, ".err"}, nerr, 0);
        chk({tag, ".n_rd"}, rd_q.size(), N);
        foreach (rd_q[i]) chk({tag, ".rd_shift"}, rd_q[i], i);
        foreach (sel_q[i]) chk({tag, ".sel"}, sel_q[i], (mode == MODE_PAR) ? (i % 2) : 0);
    endtask

    typedef struct packed {
        logic            mode;
        logic            noise;
        logic [7:0][7:0] dly;
        logic [7:0]      lat;
        logic [3:0]      nreq;
        logic [3:0]      nwr2;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0][7:0] d;
        logic            m;
        logic            nz;
        int unsigned     nacc;
        int unsigned     cnt;
        logic            hit;

        vecs[0] = '{mode: MODE_RBR, noise: 1'b0, dly: '0, lat: 8'd21, nreq: 4'd4, nwr2: 4'd0};
        vecs[1] = '{mode: MODE_PAR, noise: 1'b0, dly: '0, lat: 8'd33, nreq: 4'd8, nwr2: 4'd4};
        vecs[2] = '{mode: MODE_RBR, noise: 1'b0, dly: '0, lat: 8'd28, nreq: 4'd4, nwr2: 4'd0};
        vecs[2].dly[2] = 8'd7;
        vecs[3] = '{mode: MODE_RBR, noise: 1'b1, dly: '0, lat: 8'd21, nreq: 4'd4, nwr2: 4'd0};
        vecs[4] = '{mode: MODE_PAR, noise: 1'b0, dly: '0, lat: 8'd38, nreq: 4'd8, nwr2: 4'd4};
        vecs[4].dly[1] = 8'd3;
        vecs[4].dly[6] = 8'd2;
        vecs[5] = '{mode: MODE_PAR, noise: 1'b1, dly: '0, lat: 8'd33, nreq: 4'd8, nwr2: 4'd4};

        rst_ni  = 1'b0;
        start_i = 1'b0;
        mode_i  = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset.outs", 32'(outs), 0);
        rst_ni = 1'b1;
        @(negedge clk);
        chk("reset.idle", 32'(busy_o), 0);

        for (int unsigned i = 0; i < 6; i++) begin
            run_op(vecs[i].mode, vecs[i].noise, vecs[i].dly, vecs[i].lat, vecs[i].nreq,
                   vecs[i].nwr2, $sformatf("vec%0d", i));
        end

        // Reset asserted during ACC of plane 1.
        cur_dly = '0;
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = MODE_RBR;
        @(negedge clk);
        start_i = 1'b0;
        nacc = 0;
        hit  = 1'b0;
        for (int unsigned k = 0; k < 40 && !hit; k++) begin
            if (accum_buf_write_o) begin
                nacc++;
                if (nacc == 2) hit = 1'b1;
            end
            if (!hit) @(negedge clk);
        end
        chk("rst_mid.reached_acc1", 32'(hit), 1);
        chk("rst_mid.acc1_shift", 32'(shift_count_o), 1);
        rst_ni = 1'b0;
        #1;
        chk("rst_mid.outs_async", 32'(outs), 0);
        @(negedge clk);
        rst_ni = 1'b1;
        cnt = 0;
        for (int unsigned k = 0; k < 5; k++) begin
            @(negedge clk);
            if (busy_o || done_o || accum_buf_read_o) cnt++;
        end
        chk("rst_mid.quiet", cnt, 0);
        run_op(MODE_RBR, 1'b0, '0, 21, 4, 0, "post_rst");

        // Randomized operations against the reference model.
        for (int unsigned r = 0; r < 12; r++) begin
            m  = 1'($urandom);
            nz = 1'($urandom);
            for (int unsigned i = 0; i < 8; i++)
                d[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 6)) : 8'd0;
            run_op(m, nz, d, model_lat(m, d), (m == MODE_PAR) ? 2 * N : N,
                   (m == MODE_PAR) ? N : 0, $sformatf("rnd%0d", r));
        end

        // ADC never answers.
        cur_dly = {8{8'd255}};
        @(negedge clk);
        start_i = 1'b1;
        mode_i  = MODE_RBR;
`ifdef MAPPING_CTRL_TIMEOUT_EN
        begin
            int unsigned err_at = 0, nerr = 0, bad = 0;
            logic        busy18 = 1'b1;
            for (int unsigned k = 1; k <= 40; k++) begin
                @(negedge clk);
                start_i = 1'b0;
                if (err_o) begin
                    nerr++;
                    if (err_at == 0) err_at = k;
                end
                if (accum_buf_read_o || done_o || accum_buf_write_o) bad++;
                if (k == 18) busy18 = busy_o;
            end
            chk("timeout.err_cycle", err_at, 17);
            chk("timeout.err_pulses", nerr, 1);
            chk("timeout.busy_after", 32'(busy18), 0);
            chk("timeout.no_accum", bad, 0);
        end
`else
        begin
            int unsigned low = 0, nerr = 0;
            for (int unsigned k = 1; k <= 300; k++) begin
                @(negedge clk);
                start_i = 1'b0;
                if (!busy_o) low++;
                if (err_o) nerr++;
            end
            chk("noto.busy_held", low, 0);
            chk("noto.err_zero", nerr, 0);
            rst_ni = 1'b0;
            @(negedge clk);
            rst_ni = 1'b1;
        end
`endif
        cur_dly = '0;
        run_op(MODE_PAR, 1'b0, '0, 33, 8, 4, "after_stall");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
